// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider with tick strobe.
// Optional fractional division when CLKDIV_FRAC_EN is defined.
module clock_divider_prog #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4,
    parameter int FRAC_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef CLKDIV_FRAC_EN
    input  logic [FRAC_W-1:0] div_frac,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             div_pending,
    output logic [CNT_W-1:0] div_active
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] pend_q;
    logic             pend_v_q;
    logic [CNT_W-1:0] act_q;
    logic             clk_q, tick_q;
    logic             boundary;
    logic [CNT_W-1:0] n_new, half_new, low_len, load_n;
    logic             xtra, xtra_d;

`ifdef CLKDIV_FRAC_EN
    logic [FRAC_W-1:0] fpend_q, fact_q, acc_q, f_new, acc_d;
    logic              xtra_q;
    logic [FRAC_W:0]   acc_sum;

    assign f_new   = pend_v_q ? fpend_q : fact_q;
    assign acc_sum = {1'b0, acc_q} + {1'b0, f_new};
    assign acc_d   = acc_sum[FRAC_W-1:0];
    assign xtra_d  = acc_sum[FRAC_W];
    assign xtra    = xtra_q;
`else
    assign xtra_d  = 1'b0;
    assign xtra    = 1'b0;
`endif

    assign n_new    = pend_v_q ? pend_q : act_q;
    assign half_new = n_new >> 1;
    assign low_len  = act_q - (act_q >> 1) + CNT_W'(xtra);
    assign load_n   = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;

    // Next-state, phase counter and boundary detection
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        boundary = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d  = HIGH;
                    cnt_d    = half_new - CNT_W'(1);
                    boundary = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = low_len - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    if (en) begin
                        state_d  = HIGH;
                        cnt_d    = half_new - CNT_W'(1);
                        boundary = 1'b1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= (state_d == HIGH);
            tick_q  <= boundary;
        end
    end

    // Divisor capture; pending value is applied at the next boundary
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            act_q    <= CNT_W'(DEFAULT_DIV);
        end else begin
            if (boundary && pend_v_q)
                act_q <= pend_q;
            if (div_load) begin
                pend_q   <= load_n;
                pend_v_q <= 1'b1;
            end else if (boundary) begin
                pend_v_q <= 1'b0;
            end
        end
    end

`ifdef CLKDIV_FRAC_EN
    // Fractional accumulator; a carry stretches that period's LOW by one
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            fpend_q <= '0;
            fact_q  <= '0;
            acc_q   <= '0;
            xtra_q  <= 1'b0;
        end else begin
            if (div_load)
                fpend_q <= div_frac;
            if (boundary) begin
                fact_q <= f_new;
                acc_q  <= acc_d;
                xtra_q <= xtra_d;
            end
        end
    end
`else
    logic unused_frac;
    assign unused_frac = xtra_d;
`endif

    assign clk_out     = clk_q;
    assign tick        = tick_q;
    assign busy        = (state_q != IDLE);
    assign div_pending = pend_v_q;
    assign div_active  = act_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog.
// Compares every cycle against a period-position reference model.
module tb_clock_divider_prog;

    localparam int CNT_W  = 16;
    localparam int FRAC_W = 8;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] div_val;
    logic             div_load;
    logic [FRAC_W-1:0] div_frac;
    logic             clk_out, tick, busy, div_pending;
    logic [CNT_W-1:0] div_active;

    int checks = 0;
    int errors = 0;

    // reference model: position inside current period
    bit m_run, m_pv, m_tick;
    int m_pos, m_n, m_len, m_pend, m_acc, m_f, m_fp;

    clock_divider_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(4), .FRAC_W(FRAC_W)) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .en          (en),
        .div_val     (div_val),
        .div_load    (div_load),
`ifdef CLKDIV_FRAC_EN
        .div_frac    (div_frac),
`endif
        .clk_out     (clk_out),
        .tick        (tick),
        .busy        (busy),
        .div_pending (div_pending),
        .div_active  (div_active)
    );

    always #10 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pv = 0; m_tick = 0;
        m_pos = 0; m_n = 4; m_len = 4; m_pend = 0;
        m_acc = 0; m_f = 0; m_fp = 0;
    endtask

    task automatic model_edge();
        bit bnd;
        int sum;
        bnd = 0;
        if (!m_run) begin
            bnd = en;
        end else begin
            m_pos++;
            if (m_pos == m_len) begin
                if (en) bnd = 1;
                else begin m_run = 0; m_pos = 0; end
            end
        end
        if (bnd) begin
            if (m_pv) begin m_n = m_pend; m_f = m_fp; end
            sum   = m_acc + m_f;
            m_len = m_n + (sum >> FRAC_W);
            m_acc = sum % (1 << FRAC_W);
            m_pos = 0;
            m_run = 1;
        end
        m_tick = bnd;
        if (div_load) begin
            m_pend = (div_val < 2) ? 2 : int'(div_val);
`ifdef CLKDIV_FRAC_EN
            m_fp = int'(div_frac);
`endif
            m_pv = 1;
        end else if (bnd) begin
            m_pv = 0;
        end
    endtask

    task automatic cmp_all();
        chk("clk_out", 32'(clk_out), 32'(m_run && (m_pos < m_n / 2)));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("busy", 32'(busy), 32'(m_run));
        chk("div_pending", 32'(div_pending), 32'(m_pv));
        chk("div_active", 32'(div_active), 32'(m_n));
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        cmp_all();
        div_load = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    function automatic bit next_is_bnd();
        return (!m_run && en) || (m_run && m_pos == m_len - 1 && en);
    endfunction

    initial begin
        int guard;
        int ticks;
        rst = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0; div_frac = '0;
        #5;
        do_reset();
        #1;
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(div_pending), 32'd0);
        chk("rst_active", 32'(div_active), 32'd4);

        // default N=4 start latency and steady state
        en = 1'b1;
        step();
        chk("start_clk", 32'(clk_out), 32'd1);
        chk("start_tick", 32'(tick), 32'd1);
        run(12);

        // N=3, then N=0 clamped to 2
        div_val = 16'd3; div_load = 1'b1;
        run(12);
        div_val = 16'd0; div_load = 1'b1;
        run(8);
        chk("clamp_active", 32'(div_active), 32'd2);

        // N=4, then load N=6 mid-HIGH
        div_val = 16'd4; div_load = 1'b1;
        run(6);
        guard = 0;
        while (!m_tick && guard < 20) begin step(); guard++; end
        chk("wait_tick4", 32'(guard < 20), 32'd1);
        div_val = 16'd6; div_load = 1'b1;
        run(16);

        // load 5 in the boundary cycle with 7 pending
        div_val = 16'd7; div_load = 1'b1;
        step();
        guard = 0;
        while (!next_is_bnd() && guard < 40) begin step(); guard++; end
        chk("wait_bnd", 32'(guard < 40), 32'd1);
        div_val = 16'd5; div_load = 1'b1;
        step();
        chk("bnd_active7", 32'(div_active), 32'd7);
        chk("bnd_pending5", 32'(div_pending), 32'd1);
        run(20);
        chk("after_active5", 32'(div_active), 32'd5);

        // en=0 mid-HIGH: period completes, then idle
        guard = 0;
        while (!m_tick && guard < 20) begin step(); guard++; end
        en = 1'b0;
        run(10);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_clk", 32'(clk_out), 32'd0);

        // async reset mid-HIGH
        en = 1'b1;
        step();
        chk("pre_rst_clk", 32'(clk_out), 32'd1);
        #4;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_clk", 32'(clk_out), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        #2;
        rst = 1'b0;
        run(8);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) begin
                div_val  = 16'($urandom_range(0, 9));
                div_frac = 8'($urandom);
                div_load = 1'b1;
            end
            step();
        end

`ifdef CLKDIV_FRAC_EN
        // N=3, F=0x20: 8 ticks in 25 cycles
        do_reset();
        en = 1'b0;
        div_val = 16'd3; div_frac = 8'h20; div_load = 1'b1;
        step();
        en = 1'b1;
        guard = 0;
        while (!m_tick && guard < 10) begin step(); guard++; end
        ticks = 32'(tick);
        for (int i = 0; i < 24; i++) begin
            step();
            ticks += 32'(tick);
        end
        chk("frac_ticks", 32'(ticks), 32'd8);
`else
        ticks = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
